// File: rtl/vga_cell_scan.sv
// vga_cell_scan: display-side scan engine for the Conway board.
//
// Generates 640x480@60 VGA timing from a pixel-rate counter pair and issues one
// cell-memory read per visible pixel. The memory returns data one cycle after the
// address, so sync and display-enable are carried through two register stages to
// line up with the read data at the pixel mux. A one-cycle frame tick marks the
// start of vertical blank so the generation engine can compute the next board
// while nothing is being scanned out.
//
// Pipeline:
//   S0  hcount/vcount counters
//   S1  rd_en, rd_addr, frame_tick (plus internal copies of de/hsync/vsync)
//   S2  de, hsync_n, vsync_n (aligned to memory read data)
//
// Ports:
//   clk_i          pixel clock
//   rst_ni         synchronous active-low reset, overrides ena_i
//   ena_i          advance enable; low freezes counters and every pipeline stage
//   rd_en_o        cell memory read strobe (visible pixel)
//   rd_addr_o      cell index = cy*GridW + cx; holds last value outside active area
//   hsync_n_o      horizontal sync, active low, aligned to read data
//   vsync_n_o      vertical sync, active low, aligned to read data
//   de_o           display enable, aligned to read data
//   frame_tick_o   single-cycle pulse at start of vertical blank

module vga_cell_scan #(
   parameter int unsigned HActive   = 640,
   parameter int unsigned HFp       = 16,
   parameter int unsigned HSync     = 96,
   parameter int unsigned HBp       = 48,
   parameter int unsigned VActive   = 480,
   parameter int unsigned VFp       = 10,
   parameter int unsigned VSync     = 2,
   parameter int unsigned VBp       = 33,
   parameter int unsigned CellShift = 5,
   parameter int unsigned GridW     = 20,
   parameter int unsigned AddrW     = 9
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             ena_i,
   output logic             rd_en_o,
   output logic [AddrW-1:0] rd_addr_o,
   output logic             hsync_n_o,
   output logic             vsync_n_o,
   output logic             de_o,
   output logic             frame_tick_o
);

   localparam int unsigned HTotal = HActive + HFp + HSync + HBp;
   localparam int unsigned VTotal = VActive + VFp + VSync + VBp;
   localparam int unsigned HCntW  = $clog2(HTotal);
   localparam int unsigned VCntW  = $clog2(VTotal);

   localparam logic [HCntW-1:0] HLast      = HCntW'(HTotal - 1);
   localparam logic [HCntW-1:0] HActEnd    = HCntW'(HActive);
   localparam logic [HCntW-1:0] HSyncStart = HCntW'(HActive + HFp);
   localparam logic [HCntW-1:0] HSyncEnd   = HCntW'(HActive + HFp + HSync);
   localparam logic [HCntW-1:0] HOne       = HCntW'(1);

   localparam logic [VCntW-1:0] VLast      = VCntW'(VTotal - 1);
   localparam logic [VCntW-1:0] VActEnd    = VCntW'(VActive);
   localparam logic [VCntW-1:0] VSyncStart = VCntW'(VActive + VFp);
   localparam logic [VCntW-1:0] VSyncEnd   = VCntW'(VActive + VFp + VSync);
   localparam logic [VCntW-1:0] VOne       = VCntW'(1);

   localparam logic [AddrW-1:0] GridWC = AddrW'(GridW);

   // S0 counters
   logic [HCntW-1:0] h_q, h_d;
   logic [VCntW-1:0] v_q, v_d;

   // S1 registers
   logic             rd_en_q, rd_en_d;
   logic [AddrW-1:0] rd_addr_q, rd_addr_d;
   logic             tick_q, tick_d;
   logic             de_s1_q, de_s1_d;
   logic             hs_n_s1_q, hs_n_s1_d;
   logic             vs_n_s1_q, vs_n_s1_d;

   // S2 registers
   logic             de_q, de_d;
   logic             hs_n_q, hs_n_d;
   logic             vs_n_q, vs_n_d;

   // S0 decode
   logic             active;
   logic             hsync_hit;
   logic             vsync_hit;
   logic             tick_hit;
   logic [AddrW-1:0] cell_x;
   logic [AddrW-1:0] cell_y;
   logic [AddrW-1:0] cell_addr;

   always_comb begin
      active    = (h_q < HActEnd) && (v_q < VActEnd);
      hsync_hit = (h_q >= HSyncStart) && (h_q < HSyncEnd);
      vsync_hit = (v_q >= VSyncStart) && (v_q < VSyncEnd);
      tick_hit  = (h_q == '0) && (v_q == VActEnd);
      cell_x    = AddrW'(h_q >> CellShift);
      cell_y    = AddrW'(v_q >> CellShift);
      // GridW is a parameter, so this is a constant multiply (shift/add network).
      cell_addr = cell_y * GridWC + cell_x;
   end

   always_comb begin
      h_d       = h_q;
      v_d       = v_q;
      rd_en_d   = rd_en_q;
      rd_addr_d = rd_addr_q;
      tick_d    = 1'b0;  // a frozen cycle never carries a tick
      de_s1_d   = de_s1_q;
      hs_n_s1_d = hs_n_s1_q;
      vs_n_s1_d = vs_n_s1_q;
      de_d      = de_q;
      hs_n_d    = hs_n_q;
      vs_n_d    = vs_n_q;

      if (ena_i) begin
         if (h_q == HLast) begin
            h_d = '0;
            v_d = (v_q == VLast) ? '0 : v_q + VOne;
         end else begin
            h_d = h_q + HOne;
         end

         rd_en_d = active;
         // Outside the visible area the address is a don't-care; holding it
         // avoids toggling the memory address bus during blanking.
         if (active) begin
            rd_addr_d = cell_addr;
         end
         tick_d    = tick_hit;
         de_s1_d   = active;
         hs_n_s1_d = ~hsync_hit;
         vs_n_s1_d = ~vsync_hit;

         de_d   = de_s1_q;
         hs_n_d = hs_n_s1_q;
         vs_n_d = vs_n_s1_q;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         h_q       <= '0;
         v_q       <= '0;
         rd_en_q   <= 1'b0;
         rd_addr_q <= '0;
         tick_q    <= 1'b0;
         de_s1_q   <= 1'b0;
         hs_n_s1_q <= 1'b1;
         vs_n_s1_q <= 1'b1;
         de_q      <= 1'b0;
         hs_n_q    <= 1'b1;
         vs_n_q    <= 1'b1;
      end else begin
         h_q       <= h_d;
         v_q       <= v_d;
         rd_en_q   <= rd_en_d;
         rd_addr_q <= rd_addr_d;
         tick_q    <= tick_d;
         de_s1_q   <= de_s1_d;
         hs_n_s1_q <= hs_n_s1_d;
         vs_n_s1_q <= vs_n_s1_d;
         de_q      <= de_d;
         hs_n_q    <= hs_n_d;
         vs_n_q    <= vs_n_d;
      end
   end

   assign rd_en_o      = rd_en_q;
   assign rd_addr_o    = rd_addr_q;
   assign frame_tick_o = tick_q;
   assign de_o         = de_q;
   assign hsync_n_o    = hs_n_q;
   assign vsync_n_o    = vs_n_q;

endmodule

// File: tb/tb_vga_cell_scan.sv
// Testbench for vga_cell_scan.
// Two instances share clock, reset and enable: one with full 640x480 timing for
// line timing and addressing, one scaled down (80x55 totals, 8-pixel cells) so
// several whole frames fit in a short run. A positional model predicts every
// output from the count of enabled clock edges since reset.

module tb_vga_cell_scan;

   typedef struct packed {
      int ha; int hfp; int hsw; int hbp;
      int va; int vfp; int vsw; int vbp;
      int sh; int gw;
   } cfg_t;

   localparam cfg_t CfgB = '{640, 16, 96, 48, 480, 10, 2, 33, 5, 20};
   localparam cfg_t CfgS = '{64, 4, 8, 4, 48, 2, 2, 3, 3, 8};

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       ena = 1'b1;

   logic       rd_en_b, hs_b, vs_b, de_b, tk_b;
   logic [8:0] rd_addr_b;
   logic       rd_en_s, hs_s, vs_s, de_s, tk_s;
   logic [5:0] rd_addr_s;

   int checks = 0;
   int fails  = 0;

   always #5 clk = ~clk;

   vga_cell_scan u_big (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .ena_i        (ena),
      .rd_en_o      (rd_en_b),
      .rd_addr_o    (rd_addr_b),
      .hsync_n_o    (hs_b),
      .vsync_n_o    (vs_b),
      .de_o         (de_b),
      .frame_tick_o (tk_b)
   );

   vga_cell_scan #(
      .HActive   (64),
      .HFp       (4),
      .HSync     (8),
      .HBp       (4),
      .VActive   (48),
      .VFp       (2),
      .VSync     (2),
      .VBp       (3),
      .CellShift (3),
      .GridW     (8),
      .AddrW     (6)
   ) u_sml (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .ena_i        (ena),
      .rd_en_o      (rd_en_s),
      .rd_addr_o    (rd_addr_s),
      .hsync_n_o    (hs_s),
      .vsync_n_o    (vs_s),
      .de_o         (de_s),
      .frame_tick_o (tk_s)
   );

   // ---------------- model ----------------
   function automatic void pos(input cfg_t c, input longint k, output int h, output int v);
      longint ht, p;
      ht = longint'(c.ha + c.hfp + c.hsw + c.hbp);
      p  = k % (ht * longint'(c.va + c.vfp + c.vsw + c.vbp));
      h  = int'(p % ht);
      v  = int'(p / ht);
   endfunction

   // n = enabled edges since reset; position k is the counter value after k edges
   function automatic void model_step(input cfg_t c, inout longint n, inout int a,
                                      output bit t);
      int h, v;
      pos(c, n, h, v);
      t = (h == 0) && (v == c.va);
      if (h < c.ha && v < c.va) a = (v >> c.sh) * c.gw + (h >> c.sh);
      n = n + 1;
   endfunction

   function automatic logic [20:0] expect_vec(input cfg_t c, input longint n, input int a,
                                              input bit t);
      int h, v;
      logic en, de, hs, vs;
      logic [15:0] a16;
      en = 1'b0; de = 1'b0; hs = 1'b1; vs = 1'b1;
      a16 = a[15:0];
      if (n >= 1) begin
         pos(c, n - 1, h, v);
         en = (h < c.ha) && (v < c.va);
      end
      if (n >= 2) begin
         pos(c, n - 2, h, v);
         de = (h < c.ha) && (v < c.va);
         hs = !(h >= c.ha + c.hfp && h < c.ha + c.hfp + c.hsw);
         vs = !(v >= c.va + c.vfp && v < c.va + c.vfp + c.vsw);
      end
      return {en, a16, hs, vs, de, t};
   endfunction

   bit     mdl_on = 1'b0;
   longint nb = 0, ns = 0;
   int     ab = 0, as_ = 0;
   bit     tkb = 1'b0, tks = 1'b0;

   always @(posedge clk) begin
      if (!rst_n) begin
         mdl_on = 1'b1;
         nb = 0; ab = 0; tkb = 1'b0;
         ns = 0; as_ = 0; tks = 1'b0;
      end else if (ena) begin
         model_step(CfgB, nb, ab, tkb);
         model_step(CfgS, ns, as_, tks);
      end else begin
         tkb = 1'b0;
         tks = 1'b0;
      end
   end

   task automatic cmp_vec(input string name, input logic [20:0] got, input logic [20:0] want);
      checks++;
      if (got !== want) begin
         fails++;
         $display("FAIL %s @%0t got rd_en=%b addr=%0d hs_n=%b vs_n=%b de=%b tick=%b want rd_en=%b addr=%0d hs_n=%b vs_n=%b de=%b tick=%b",
                  name, $time, got[20], got[19:4], got[3], got[2], got[1], got[0],
                  want[20], want[19:4], want[3], want[2], want[1], want[0]);
      end
   endtask

   always @(negedge clk) begin
      if (mdl_on) begin
         cmp_vec("model_big", {rd_en_b, 16'(rd_addr_b), hs_b, vs_b, de_b, tk_b},
                 expect_vec(CfgB, nb, ab, tkb));
         cmp_vec("model_sml", {rd_en_s, 16'(rd_addr_s), hs_s, vs_s, de_s, tk_s},
                 expect_vec(CfgS, ns, as_, tks));
      end
   end

   // ---------------- directed checks ----------------
   task automatic chk(input string name, input longint got, input longint want);
      checks++;
      if (got != want) begin
         fails++;
         $display("FAIL %s got=%0d want=%0d", name, got, want);
      end
   endtask

   int t = 0;
   int de_rise_b[$], de_fall_b[$], hs_fall_b[$], hs_rise_b[$], tick_b[$];
   int de_rise_s[$], tick_s[$], vs_fall_s[$], vs_rise_s[$];
   logic de_pb = 1'b0, hs_pb = 1'b1, de_ps = 1'b0, vs_ps = 1'b1;

   task automatic step();
      @(negedge clk);
      t++;
      if (de_b && !de_pb) de_rise_b.push_back(t);
      if (!de_b && de_pb) de_fall_b.push_back(t);
      if (!hs_b && hs_pb) hs_fall_b.push_back(t);
      if (hs_b && !hs_pb) hs_rise_b.push_back(t);
      if (tk_b) tick_b.push_back(t);
      if (de_s && !de_ps) de_rise_s.push_back(t);
      if (!vs_s && vs_ps) vs_fall_s.push_back(t);
      if (vs_s && !vs_ps) vs_rise_s.push_back(t);
      if (tk_s) tick_s.push_back(t);
      de_pb = de_b; hs_pb = hs_b; de_ps = de_s; vs_ps = vs_s;
   endtask

   function automatic int qget(input int q[$], input int i);
      if (i < q.size()) return q[i];
      return -1000000;
   endfunction

   function automatic int first_after(input int q[$], input int x);
      foreach (q[i]) if (q[i] > x) return q[i];
      return -1000000;
   endfunction

   function automatic int last_upto(input int q[$], input int x);
      int r;
      r = -1000000;
      foreach (q[i]) if (q[i] <= x) r = q[i];
      return r;
   endfunction

   task automatic chk_reset(input string tag);
      chk({tag, "_rd_en_b"}, rd_en_b, 0);
      chk({tag, "_rd_addr_b"}, rd_addr_b, 0);
      chk({tag, "_hs_b"}, hs_b, 1);
      chk({tag, "_vs_b"}, vs_b, 1);
      chk({tag, "_de_b"}, de_b, 0);
      chk({tag, "_tick_b"}, tk_b, 0);
      chk({tag, "_rd_en_s"}, rd_en_s, 0);
      chk({tag, "_rd_addr_s"}, rd_addr_s, 0);
      chk({tag, "_de_s"}, de_s, 0);
   endtask

   int rel1, rel2, fz;

   initial begin
      rst_n = 1'b0;
      ena   = 1'b1;
      repeat (5) step();
      chk_reset("rst");

      rst_n = 1'b1;
      rel1  = t;
      while (t - rel1 < 56101) begin
         step();
         if (t - rel1 == 9)     chk("addr_s_8_0", rd_addr_s, 1);
         if (t - rel1 == 33)    chk("addr_b_32_0", rd_addr_b, 1);
         if (t - rel1 == 641)   chk("addr_s_0_8", rd_addr_s, 8);
         if (t - rel1 == 3824)  chk("addr_s_63_47", rd_addr_s, 47);
         if (t - rel1 == 25601) chk("addr_b_0_32", rd_addr_b, 20);
         if (t - rel1 == 56101) chk("addr_b_100_70", rd_addr_b, 43);
      end

      chk("b_first_de", qget(de_rise_b, 0) - rel1, 2);
      chk("b_line_period", qget(de_rise_b, 1) - qget(de_rise_b, 0), 800);
      chk("b_de_len0", qget(de_fall_b, 0) - qget(de_rise_b, 0), 640);
      chk("b_de_len1", qget(de_fall_b, 1) - qget(de_rise_b, 1), 640);
      chk("b_hs_after_de", qget(hs_fall_b, 0) - qget(de_rise_b, 0), 656);
      chk("b_hs_len0", qget(hs_rise_b, 0) - qget(hs_fall_b, 0), 96);
      chk("b_hs_len1", qget(hs_rise_b, 1) - qget(hs_fall_b, 1), 96);
      chk("b_no_tick_yet", tick_b.size(), 0);
      chk("s_first_de", qget(de_rise_s, 0) - rel1, 2);
      chk("s_first_tick", qget(tick_s, 0) - rel1, 3841);
      chk("s_tick_period", qget(tick_s, 1) - qget(tick_s, 0), 4400);
      chk("s_tick_count", tick_s.size(), 12);
      chk("s_vs_start", qget(vs_fall_s, 0) - rel1, 4002);
      chk("s_vs_len", qget(vs_rise_s, 0) - qget(vs_fall_s, 0), 160);

      // freeze mid-line for 37 edges
      fz  = t;
      ena = 1'b0;
      repeat (37) step();
      chk("frz_rd_addr_b", rd_addr_b, 43);
      chk("frz_rd_en_b", rd_en_b, 1);
      chk("frz_de_b", de_b, 1);
      chk("frz_rd_addr_s", rd_addr_s, 42);
      ena = 1'b1;
      while (t - rel1 < 56720) step();
      chk("b_gated_line_de",
          first_after(de_fall_b, fz) - last_upto(de_rise_b, fz) - 37, 640);
      chk("s_tick_after_gap", first_after(tick_s, fz) - rel1, 56678);

      // one-cycle reset at small-instance line 30
      while (t - rel1 < 59677) step();
      chk("pre_rst_addr_s", rd_addr_s, 28);
      rst_n = 1'b0;
      step();
      chk_reset("midrst");
      rst_n = 1'b1;
      rel2  = t;
      while (t - rel2 < 3900) step();
      chk("s_tick_after_rst", first_after(tick_s, rel2) - rel2, 3841);
      chk("b_de_after_rst", first_after(de_rise_b, rel2) - rel2, 2);
      chk("s_de_after_rst", first_after(de_rise_s, rel2) - rel2, 2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule

// File: doc/vga_cell_scan.md
Name: vga_cell_scan

Overview:
- Display-side scan engine for the Conway board, one stage downstream of the generation engine's cell memory.
- Generates 640x480@60 VGA timing and issues a cell-memory read address per pixel.
- Delays hsync, vsync and display-enable so they align with the memory's 1-cycle read data at the pixel mux.
- Emits a one-cycle frame tick at start of vertical blank. The generation engine uses it to compute the next board while the screen is blank.

Parameters:
- H_ACTIVE, 640: visible pixels per line.
- H_FP, 16: horizontal front porch.
- H_SYNC, 96: hsync pulse width.
- H_BP, 48: horizontal back porch (H_TOTAL = 800).
- V_ACTIVE, 480: visible lines.
- V_FP, 10: vertical front porch.
- V_SYNC, 2: vsync width.
- V_BP, 33: vertical back porch (V_TOTAL = 525).
- CELL_SHIFT, 5: log2 of cell size in pixels (32x32 cells).
- GRID_W, 20: cells per row; must equal H_ACTIVE >> CELL_SHIFT.
- ADDR_W, 9: cell address width; must satisfy GRID_W*GRID_H <= 2^ADDR_W (GRID_H = 15).

Ports:
- clk  in  1  pixel clock (25.175 MHz nominal)
- rst_n  in  1  reset, synchronous, active-low
- ena  in  1  advance enable; 0 freezes the block
- rd_en  out  1  cell memory read strobe (active-region pixel)
- rd_addr  out  ADDR_W  cell index = cy*GRID_W + cx
- hsync_n  out  1  horizontal sync, active low, aligned to read data
- vsync_n  out  1  vertical sync, active low, aligned to read data
- de  out  1  display enable, aligned to read data
- frame_tick  out  1  single-cycle pulse at start of vblank

Behaviour:
- Reset (rst_n low at a clk edge), applied that edge, overriding ena:
  - hcount=0, vcount=0.
  - rd_en=0, rd_addr=0, hsync_n=1, vsync_n=1, de=0, frame_tick=0.
  - All pipeline delay registers clear to the inactive values above.
- Counters (stage S0):
  - hcount runs 0..H_TOTAL-1 and wraps to 0.
  - On the hcount wrap, vcount increments; it wraps V_TOTAL-1 -> 0 on the same edge as the hcount wrap.
- Active region: hcount < H_ACTIVE and vcount < V_ACTIVE.
- S1, registered from S0:
  - rd_en = active.
  - rd_addr = (vcount>>CELL_SHIFT)*GRID_W + (hcount>>CELL_SHIFT) when active; holds its last value when not active.
  - Multiply by a constant only; no general multiplier.
- S2 (data valid from memory):
  - de = active delayed 2 cycles.
  - hsync_n = 0 iff H_ACTIVE+H_FP <= hcount < H_ACTIVE+H_FP+H_SYNC (656..751), delayed 2 cycles.
  - vsync_n = 0 iff V_ACTIVE+V_FP <= vcount < V_ACTIVE+V_FP+V_SYNC (490..491), delayed 2 cycles.
- Latency: counter value to rd_addr is 1 cycle; counter value to de/hsync_n/vsync_n is 2 cycles.
- frame_tick:
  - Registered at S1, asserted for exactly one cycle when S0 is at (hcount=0, vcount=V_ACTIVE).
  - One pulse per frame = every 420000 enabled cycles.
- ena=0:
  - Counters and all pipeline registers hold.
  - frame_tick is forced 0 during that cycle and does not re-fire on resume unless the counters newly reach the tick point.
  - Resume continues exactly where it stopped; no skipped or duplicated pixels.
- Reset mid-frame: restarts at (0,0) the next edge. The first frame after reset produces a full 480-line active region before its first frame_tick.
- Max address: 299 at pixel (639,479). Out-of-grid addresses are never issued.

Test Plan:
- Reset: hold rst_n=0 for 5 cycles with ena=1 -> rd_en=0, rd_addr=0, hsync_n=1, vsync_n=1, de=0, frame_tick=0. Release -> first de=1 appears exactly 2 cycles after release.
- Line timing: run 2 lines -> per line, de high 640 cycles and hsync_n low 96 cycles. hsync_n falls 656 cycles after de rises; line period is 800.
- Addressing: sample rd_addr 1 cycle after counter (h=100,v=70) -> 43; at (639,479) -> 299; at (32,0) -> 1; at (0,32) -> 20.
- Frame: run 2 full frames -> frame_tick pulses once per 420000 cycles, first pulse 384001 cycles after reset release. vsync_n low exactly 1600 cycles, starting at line 490.
- ena gating: drop ena for 37 cycles mid-line -> all outputs frozen. After resume, de total for that line is still 640 and the next frame_tick is delayed by exactly 37 cycles.
- Reset mid-frame: assert rst_n=0 for 1 cycle at line 300 -> outputs return to reset values next edge. Timing then restarts at (0,0), with no frame_tick until 384001 cycles later.
